// File: rtl/decoder_nx_seq.sv
// N-to-2**N decoder with a registered valid/ready output beat and a
// self-running scan mode that walks every code from 0 to M-1.
module decoder_nx_seq #(
    parameter int N          = 3,
    parameter bit REVERSE    = 1'b1,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        a_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                scan_start,
    output logic                busy,
    output logic [(1<<N)-1:0]   d_out,
    output logic [N-1:0]        code_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                scan_done
);

    localparam int M = 1 << N;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t       state_q, state_d;
    logic         pend_q, pend_d;
    logic [N-1:0] code_q, code_d;
    logic         vld_q, vld_d;
    logic         done_q, done_d;

    logic         free;
    logic         xfer;
    logic         last;
    logic [N-1:0] idx;
    logic [M-1:0] hot;

    assign free = !vld_q || out_ready;
    assign xfer = vld_q && out_ready;
    assign last = (code_q == N'(M - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            code_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        code_d  = code_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d = SCAN;
                    if (free) begin
                        code_d = '0;
                        vld_d  = 1'b1;
                    end else begin
                        pend_d = 1'b1;
                    end
                end else if (in_valid && free) begin
                    code_d = a_in;
                    vld_d  = 1'b1;
                end else if (xfer) begin
                    vld_d = 1'b0;
                end
            end
            SCAN: begin
                // a held request waits for the old beat to leave
                if (pend_q) begin
                    if (free) begin
                        code_d = '0;
                        vld_d  = 1'b1;
                        pend_d = 1'b0;
                    end
                end else if (xfer) begin
                    if (last) begin
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        code_d = code_q + N'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // M-1-k equals the bitwise inverse of k in N bits
    assign idx = REVERSE ? ~code_q : code_q;

    always_comb begin
        hot = '0;
        if (vld_q) hot[idx] = 1'b1;
    end

    assign d_out     = ACTIVE_LOW ? ~hot : hot;
    assign code_out  = code_q;
    assign out_valid = vld_q;
    assign busy      = (state_q == SCAN);
    assign scan_done = done_q;
    assign in_ready  = (state_q == IDLE) && free && !scan_start;

endmodule
